syscall_unit: RTL and testbench
===============================

Name: syscall_unit

Overview:
- Parametrised, sequential successor to the inline ecall decode in the CPU top level.
- Accepts one ecall request per instruction from the control path and executes halt, system-memory write, graphics write, LED bit ops and keyboard read.
- Stalls the PC while a call is outstanding; waits on GPU and keyboard handshakes.
- Sits between CU/register file and SMEM, GPU, LEDs and the keyboard scanner.

Parameters:
- DATA_W, 32, width of arg_data, result, smem_data and gmem_data.
- ADDR_W, 32, width of arg_addr, smem_addr and gmem_addr.
- CODE_W, 5, syscode width.
- LED_N, 4, number of LED outputs.
- TIMEOUT_CYC, 1024, wait limit in cycles, used only with the optional feature.

Ports:
- CLK_50  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- ecall  in  1  request valid, one-cycle pulse from CU.
- syscode  in  CODE_W  call number.
- arg_addr  in  ADDR_W  address argument from register file.
- arg_data  in  DATA_W  data argument from register file.
- busy  out  1  stall to PC; high while the call is not complete.
- run  out  1  core-enable; low after HALT.
- result  out  DATA_W  value returned by KEY_READ.
- result_valid  out  1  one-cycle write-back strobe for result.
- err  out  1  sticky unknown-syscode flag.
- smem_we  out  1  system-memory write enable.
- smem_addr  out  ADDR_W  system-memory address.
- smem_data  out  DATA_W  system-memory write data.
- gmem_valid  out  1  graphics command valid.
- gmem_ready  in  1  GPU accepts command.
- gmem_addr  out  ADDR_W  graphics address.
- gmem_data  out  DATA_W  graphics command data.
- key_valid  in  1  keyboard code available.
- key_data  in  8  keyboard code.
- key_ack  out  1  one-cycle pop to keyboard scanner.
- led  out  LED_N  LED register.

Behaviour:
- Reset, asynchronous on RST_N low: state IDLE, run=1, busy=0, all strobes 0, result=0, err=0, led=0, address/data regs=0.
- Reset mid-call aborts the call with no partial side effects.
- syscode, arg_addr and arg_data are latched on the accepted ecall edge.
- ecall is accepted only in IDLE. An ecall in any other state is ignored; CU must not issue while busy=1.
- busy is combinationally high in the cycle ecall is accepted, and stays high until the completing cycle.
- States: IDLE, SMEM_WR, GMEM_WAIT, KEY_WAIT, HALTED.
- 0 HALT: next state HALTED, run=0, busy=0. Only reset leaves HALTED.
- 1 SMEM_WRITE: SMEM_WR for exactly 1 cycle with smem_we=1, smem_addr/smem_data = latched arguments, then IDLE. Latency 1 cycle.
- 2 GMEM_WRITE: GMEM_WAIT. gmem_valid=1 with stable addr/data until sampled gmem_valid&&gmem_ready, then IDLE.
  - If gmem_ready is already high in the first GMEM_WAIT cycle, completion takes 1 cycle.
- 3 LED_SET, 4 LED_CLR, 5 LED_TOG: operate on bit arg_data[$clog2(LED_N)-1:0]; led updates the next edge; no busy cycle.
  - Index >= LED_N: led unchanged and err set.
- 6 KEY_READ: KEY_WAIT until key_valid=1. In that cycle: key_ack=1, result = zero-extended key_data, result_valid=1, return to IDLE.
- Any other code: err set (sticky until reset), no other effect, no busy cycle.
- Valid ops between reset and the first ecall: none.

Optional Feature:
- Macro SYSCALL_TIMEOUT_EN.
- Defined: a counter runs in GMEM_WAIT and KEY_WAIT. When it reaches TIMEOUT_CYC:
  - the state forces to IDLE and err is set;
  - KEY_READ additionally returns result=all-ones with result_valid=1;
  - the counter clears on every state entry.
- Undefined: waits are unbounded, no counter logic.

Decomposition:
- Shared package holds:
  - the syscode localparams (SC_HALT=0, SC_SMEM=1, SC_GMEM=2, SC_LED_SET=3, SC_LED_CLR=4, SC_LED_TOG=5, SC_KEY=6);
  - the state enum type;
  - DATA_W/ADDR_W defaults used by the CPU top level.
- One natural sub-module: syscall_led_reg, the LED_N-bit set/clear/toggle register with range check.

Test Plan:
- Reset low mid-GMEM_WAIT -> gmem_valid=0, busy=0, state IDLE, led=0 immediately, before the clock edge.
- ecall code 1, addr=0x10, data=0xDEADBEEF -> smem_we=1 for exactly 1 cycle with those values; busy high 1 cycle.
- ecall code 2, gmem_ready held low 5 cycles then high -> gmem_valid high 6 cycles, addr/data stable, busy released after the handshake.
- LED_N=4: SET idx 2, TOG idx 0, CLR idx 2, SET idx 7 -> led 0100, 0101, 0001, unchanged with err=1.
- ecall code 6, key_valid asserted after 3 cycles with 0x41 -> result=0x00000041, result_valid and key_ack 1 cycle.
- ecall code 0, then further ecalls -> run=0 and stays 0, ecalls ignored; with SYSCALL_TIMEOUT_EN and TIMEOUT_CYC=8, KEY_READ with no key -> result=0xFFFFFFFF and err=1 after 8 cycles.

Source files
------------

// File: rtl/syscall_unit_pkg.sv
// -----------------------------------------------------------------------------
// syscall_unit_pkg
// Shared definitions for the ecall execution unit:
//   - SYS_DATA_W / SYS_ADDR_W : datapath width defaults used by the CPU top level
//   - SC_*                    : syscode numbers decoded by syscall_unit
//   - sys_state_e             : syscall_unit FSM states
//   - led_op_e                : operation request to the LED register
// -----------------------------------------------------------------------------
package syscall_unit_pkg;

    localparam int SYS_DATA_W = 32;
    localparam int SYS_ADDR_W = 32;

    localparam int unsigned SC_HALT    = 0;
    localparam int unsigned SC_SMEM    = 1;
    localparam int unsigned SC_GMEM    = 2;
    localparam int unsigned SC_LED_SET = 3;
    localparam int unsigned SC_LED_CLR = 4;
    localparam int unsigned SC_LED_TOG = 5;
    localparam int unsigned SC_KEY     = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SMEM_WR,
        ST_GMEM_WAIT,
        ST_KEY_WAIT,
        ST_HALTED
    } sys_state_e;

    typedef enum logic [1:0] {
        LED_NOP,
        LED_SET,
        LED_CLR,
        LED_TOG
    } led_op_e;

endpackage

// File: rtl/syscall_led_reg.sv
// -----------------------------------------------------------------------------
// syscall_led_reg
// LED_N-bit LED register with single-bit set / clear / toggle and range check.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (led clears to 0)
//   op_i         : requested operation (LED_NOP when idle)
//   idx_i        : bit index, full argument width so large values are rejected
//   led_o        : registered LED state
//   range_err_o  : combinational, high when an operation names idx >= LED_N
// -----------------------------------------------------------------------------
module syscall_led_reg
    import syscall_unit_pkg::*;
#(
    parameter int LED_N = 4,
    parameter int IDX_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  led_op_e          op_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [LED_N-1:0] led_o,
    output logic             range_err_o
);

    localparam int SEL_W = (LED_N > 1) ? $clog2(LED_N) : 1;

    logic             in_range;
    logic [LED_N-1:0] mask;
    logic [LED_N-1:0] led_q, led_d;

    // The range check looks at the whole index, not just the low select bits,
    // so an index such as 7 with LED_N=4 is rejected instead of aliasing to 3.
    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        in_range    = (idx_i < IDX_W'(LED_N));
        mask        = in_range ? (LED_N'(1) << idx_i[SEL_W-1:0]) : '0;
        range_err_o = (op_i != LED_NOP) && !in_range;
        led_d       = led_q;
        case (op_i)
            LED_SET: led_d = led_q | mask;
            LED_CLR: led_d = led_q & ~mask;
            LED_TOG: led_d = led_q ^ mask;
            default: led_d = led_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/syscall_unit.sv
// -----------------------------------------------------------------------------
// syscall_unit
// Sequential ecall executor between the control unit / register file and the
// system memory, GPU, LED bank and keyboard scanner.
//   HALT, SMEM_WRITE, GMEM_WRITE, LED_SET/CLR/TOG, KEY_READ; other codes set err.
// Optional build macro: SYSCALL_TIMEOUT_EN -- bounds GMEM_WAIT / KEY_WAIT to
// TIMEOUT_CYC cycles (forced return to IDLE, err set, KEY_READ returns all-ones).
// Ports:
//   CLK_50, RST_N                  : clock, asynchronous active-low reset
//   ecall, syscode, arg_addr/data  : request from CU / register file
//   busy, run                      : PC stall, core enable (low once halted)
//   result, result_valid           : KEY_READ write-back value and strobe
//   err                            : sticky bad-syscode / bad-LED-index / timeout flag
//   smem_we/addr/data              : system-memory write port
//   gmem_valid/ready/addr/data     : graphics command handshake
//   key_valid/data, key_ack        : keyboard scanner handshake
//   led                            : LED register
// -----------------------------------------------------------------------------
module syscall_unit
    import syscall_unit_pkg::*;
#(
    parameter int DATA_W = SYS_DATA_W,
    parameter int ADDR_W = SYS_ADDR_W,
    parameter int CODE_W = 5,
    parameter int LED_N  = 4
`ifdef SYSCALL_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic              CLK_50,
    input  logic              RST_N,
    input  logic              ecall,
    input  logic [CODE_W-1:0] syscode,
    input  logic [ADDR_W-1:0] arg_addr,
    input  logic [DATA_W-1:0] arg_data,
    output logic              busy,
    output logic              run,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              err,
    output logic              smem_we,
    output logic [ADDR_W-1:0] smem_addr,
    output logic [DATA_W-1:0] smem_data,
    output logic              gmem_valid,
    input  logic              gmem_ready,
    output logic [ADDR_W-1:0] gmem_addr,
    output logic [DATA_W-1:0] gmem_data,
    input  logic              key_valid,
    input  logic [7:0]        key_data,
    output logic              key_ack,
    output logic [LED_N-1:0]  led
);

    sys_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              err_q, err_d;
    logic [31:0]       code_ext;
    led_op_e           led_op;
    logic              led_range_err;

`ifdef SYSCALL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting;
    logic             timeout;

    assign waiting = (state_q == ST_GMEM_WAIT) || (state_q == ST_KEY_WAIT);
    // Counter holds the number of wait cycles already spent, so the limit is
    // hit in the TIMEOUT_CYC-th wait cycle.
    assign timeout = waiting && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

    assign code_ext = 32'(syscode);

    // The state alone records which call is in flight, so only the address and
    // data arguments need latching on the accepted edge.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        err_d        = err_q;
        result_d     = result_q;
        result       = result_q;
        result_valid = 1'b0;
        key_ack      = 1'b0;
        busy         = 1'b0;
        led_op       = LED_NOP;

        case (state_q)
            ST_IDLE: begin
                if (ecall) begin
                    addr_d = arg_addr;
                    data_d = arg_data;
                    case (code_ext)
                        SC_HALT:    state_d = ST_HALTED;
                        SC_SMEM:    begin state_d = ST_SMEM_WR;   busy = 1'b1; end
                        SC_GMEM:    begin state_d = ST_GMEM_WAIT; busy = 1'b1; end
                        SC_KEY:     begin state_d = ST_KEY_WAIT;  busy = 1'b1; end
                        SC_LED_SET: led_op = LED_SET;
                        SC_LED_CLR: led_op = LED_CLR;
                        SC_LED_TOG: led_op = LED_TOG;
                        default:    err_d = 1'b1;
                    endcase
                end
            end
            ST_SMEM_WR: state_d = ST_IDLE;
            ST_GMEM_WAIT: begin
                if (gmem_ready) state_d = ST_IDLE;
                else            busy    = 1'b1;
            end
            ST_KEY_WAIT: begin
                if (key_valid) begin
                    key_ack      = 1'b1;
                    result       = DATA_W'(key_data);
                    result_d     = DATA_W'(key_data);
                    result_valid = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase

`ifdef SYSCALL_TIMEOUT_EN
        // A handshake completing in the limit cycle wins over the timeout.
        if (timeout && (state_d == state_q)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            busy    = 1'b0;
            if (state_q == ST_KEY_WAIT) begin
                result       = '1;
                result_d     = '1;
                result_valid = 1'b1;
            end
        end
        cnt_d = (waiting && (state_d == state_q)) ? cnt_q + 1'b1 : '0;
`endif
    end

    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            result_q <= result_d;
            err_q    <= err_d | led_range_err;
        end
    end

`ifdef SYSCALL_TIMEOUT_EN
    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    syscall_led_reg #(
        .LED_N (LED_N),
        .IDX_W (DATA_W)
    ) u_led (
        .clk         (CLK_50),
        .rst_n       (RST_N),
        .op_i        (led_op),
        .idx_i       (arg_data),
        .led_o       (led),
        .range_err_o (led_range_err)
    );

    assign run        = (state_q != ST_HALTED);
    assign err        = err_q;
    assign smem_we    = (state_q == ST_SMEM_WR);
    assign smem_addr  = addr_q;
    assign smem_data  = data_q;
    assign gmem_valid = (state_q == ST_GMEM_WAIT);
    assign gmem_addr  = addr_q;
    assign gmem_data  = data_q;

endmodule

// File: tb/tb_syscall_unit.sv
// -----------------------------------------------------------------------------
// tb_syscall_unit
// Scoreboard bench for syscall_unit. Expected memory writes, graphics commands
// and keyboard results are queued when a call is issued; a monitor pops and
// compares them whenever the DUT presents the matching strobe. LED, err, run
// and busy-length expectations come from a call-level reference model.
// Build with SYSCALL_TIMEOUT_EN to add the timeout scenario (TIMEOUT_CYC=8).
// -----------------------------------------------------------------------------
module tb_syscall_unit;
    import syscall_unit_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CODE_W = 5;
    localparam int LED_N  = 4;
`ifdef SYSCALL_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 8;
`endif

    logic              CLK_50 = 1'b0;
    logic              RST_N  = 1'b1;
    logic              ecall  = 1'b0;
    logic [CODE_W-1:0] syscode  = '0;
    logic [ADDR_W-1:0] arg_addr = '0;
    logic [DATA_W-1:0] arg_data = '0;
    logic              busy, run, result_valid, err;
    logic [DATA_W-1:0] result;
    logic              smem_we, gmem_valid, key_ack;
    logic [ADDR_W-1:0] smem_addr, gmem_addr;
    logic [DATA_W-1:0] smem_data, gmem_data;
    logic              gmem_ready = 1'b0;
    logic              key_valid  = 1'b0;
    logic [7:0]        key_data   = '0;
    logic [LED_N-1:0]  led;

    always #10 CLK_50 = ~CLK_50;

    syscall_unit #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CODE_W (CODE_W),
        .LED_N  (LED_N)
`ifdef SYSCALL_TIMEOUT_EN
        , .TIMEOUT_CYC (TIMEOUT_CYC)
`endif
    ) dut (
        .CLK_50       (CLK_50),
        .RST_N        (RST_N),
        .ecall        (ecall),
        .syscode      (syscode),
        .arg_addr     (arg_addr),
        .arg_data     (arg_data),
        .busy         (busy),
        .run          (run),
        .result       (result),
        .result_valid (result_valid),
        .err          (err),
        .smem_we      (smem_we),
        .smem_addr    (smem_addr),
        .smem_data    (smem_data),
        .gmem_valid   (gmem_valid),
        .gmem_ready   (gmem_ready),
        .gmem_addr    (gmem_addr),
        .gmem_data    (gmem_data),
        .key_valid    (key_valid),
        .key_data     (key_data),
        .key_ack      (key_ack),
        .led          (led)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; } mem_exp_t;
    typedef struct { logic [31:0] value; logic ack; } res_exp_t;

    int total = 0;
    int bad   = 0;

    mem_exp_t smem_exp[$];
    mem_exp_t gmem_exp[$];
    res_exp_t res_exp[$];

    // Reference model state
    logic [LED_N-1:0] led_m    = '0;
    logic             err_m    = 1'b0;
    bit               halted_m = 1'b0;

    // Responder controls
    int         gmem_delay = 0;
    int         g_cnt      = 0;
    bit         key_arm    = 1'b0;
    int         key_wait   = 0;
    logic [7:0] key_code   = '0;
    bit         ack_seen   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        mem_exp_t m;
        res_exp_t r;
        forever begin
            @(negedge CLK_50);
            ack_seen = key_ack;
            if (smem_we) begin
                if (smem_exp.size() == 0) begin
                    check("smem_we_unexpected", smem_we, 0);
                end else begin
                    m = smem_exp.pop_front();
                    check("smem_addr", smem_addr, m.addr);
                    check("smem_data", smem_data, m.data);
                end
            end
            if (gmem_valid && gmem_exp.size() != 0) begin
                check("gmem_addr", gmem_addr, gmem_exp[0].addr);
                check("gmem_data", gmem_data, gmem_exp[0].data);
                if (gmem_ready) void'(gmem_exp.pop_front());
            end else if (gmem_valid && gmem_ready) begin
                check("gmem_unexpected", gmem_valid, 0);
            end
            if (result_valid) begin
                if (res_exp.size() == 0) begin
                    check("result_valid_unexpected", result_valid, 0);
                end else begin
                    r = res_exp.pop_front();
                    check("result", result, r.value);
                    check("key_ack", key_ack, r.ack);
                end
            end else if (key_ack) begin
                check("key_ack_alone", key_ack, 0);
            end
        end
    endtask

    // GPU and keyboard stand-ins; they change inputs 2 time units after the edge.
    task automatic responders();
        forever begin
            @(posedge CLK_50);
            #2;
            if (gmem_valid) begin
                gmem_ready = (g_cnt >= gmem_delay);
                g_cnt++;
            end else begin
                gmem_ready = 1'b0;
                g_cnt      = 0;
            end
            if (key_valid) begin
                if (ack_seen) begin
                    key_valid = 1'b0;
                    key_arm   = 1'b0;
                end
            end else if (key_arm) begin
                if (key_wait == 0) begin
                    key_valid = 1'b1;
                    key_data  = key_code;
                end else begin
                    key_wait--;
                end
            end
        end
    endtask

    // Pulses ecall for one cycle and counts the cycles busy is high.
    task automatic run_call(input int code, input logic [31:0] a, input logic [31:0] d,
                            input bit arm, output int busy_n);
        @(posedge CLK_50);
        #1;
        ecall    = 1'b1;
        syscode  = CODE_W'(code);
        arg_addr = a;
        arg_data = d;
        busy_n   = 0;
        @(negedge CLK_50);
        if (busy) busy_n++;
        @(posedge CLK_50);
        #1;
        ecall    = 1'b0;
        arg_addr = $urandom;   // arguments must already be latched
        arg_data = $urandom;
        syscode  = CODE_W'($urandom);
        if (arm) key_arm = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK_50);
            if (!busy) break;
            busy_n++;
        end
    endtask

    // delay: GPU ready delay or keyboard delay; delay < 0 on KEY_READ means no key.
    task automatic issue(input int code, input logic [31:0] a, input logic [31:0] d,
                         input int delay, input logic [7:0] kbyte);
        int       exp_busy;
        int       busy_n;
        bit       arm;
        mem_exp_t m;
        res_exp_t r;
        exp_busy = 0;
        arm      = 1'b0;
        if (!halted_m) begin
            case (code)
                0: halted_m = 1'b1;
                1: begin m.addr = a; m.data = d; smem_exp.push_back(m); exp_busy = 1; end
                2: begin
                    m.addr = a; m.data = d; gmem_exp.push_back(m);
                    gmem_delay = delay;
                    exp_busy   = delay + 1;
                end
                3, 4, 5: begin
                    if (d < 32'(LED_N)) begin
                        if (code == 3)      led_m[d[1:0]] = 1'b1;
                        else if (code == 4) led_m[d[1:0]] = 1'b0;
                        else                led_m[d[1:0]] = ~led_m[d[1:0]];
                    end else begin
                        err_m = 1'b1;
                    end
                end
                6: begin
`ifdef SYSCALL_TIMEOUT_EN
                    if (delay < 0) begin
                        r.value = 32'hFFFF_FFFF; r.ack = 1'b0;
                        res_exp.push_back(r);
                        exp_busy = TIMEOUT_CYC;
                        err_m    = 1'b1;
                    end else
`endif
                    begin
                        key_code = kbyte;
                        key_wait = delay;
                        arm      = 1'b1;
                        r.value  = {24'h0, kbyte}; r.ack = 1'b1;
                        res_exp.push_back(r);
                        exp_busy = delay + 1;
                    end
                end
                default: err_m = 1'b1;
            endcase
        end
        run_call(code, a, d, arm, busy_n);
        check($sformatf("busy_cycles_code%0d", code), busy_n, exp_busy);
        @(negedge CLK_50);
        check("led", led, led_m);
        check("err", err, err_m);
        check("run", run, !halted_m);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        fork
            monitor();
            responders();
        join_none

        // Reset values
        #1 RST_N = 1'b0;
        #4;
        check("rst_busy", busy, 0);
        check("rst_run", run, 1);
        check("rst_led", led, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_smem_we", smem_we, 0);
        check("rst_gmem_valid", gmem_valid, 0);
        check("rst_key_ack", key_ack, 0);
        check("rst_smem_addr", smem_addr, 0);
        check("rst_gmem_data", gmem_data, 0);
        @(negedge CLK_50);
        @(negedge CLK_50);
        RST_N = 1'b1;

        // Directed calls
        issue(1, 32'h10, 32'hDEAD_BEEF, 0, 8'h00);
        issue(2, 32'h2000, 32'hCAFE_F00D, 5, 8'h00);
        issue(2, 32'h2004, 32'h1234_5678, 0, 8'h00);
        issue(6, 32'h0, 32'h0, 3, 8'h41);
        check("result_hold", result, 32'h41);
        issue(6, 32'h0, 32'h0, 0, 8'hA5);
        issue(3, $urandom, 32'd2, 0, 8'h00);
        check("led_set2", led, 4'b0100);
        issue(5, $urandom, 32'd0, 0, 8'h00);
        check("led_tog0", led, 4'b0101);
        issue(4, $urandom, 32'd2, 0, 8'h00);
        check("led_clr2", led, 4'b0001);
        issue(3, $urandom, 32'd7, 0, 8'h00);
        check("led_set7_unchanged", led, 4'b0001);
        check("led_set7_err", err, 1);

        // Reset while a graphics command is waiting
        issue(3, $urandom, 32'd1, 0, 8'h00);
        gmem_delay = 1000;
        @(posedge CLK_50);
        #1;
        ecall = 1'b1; syscode = CODE_W'(SC_GMEM); arg_addr = 32'h3000; arg_data = 32'h5555;
        @(posedge CLK_50);
        #1;
        ecall = 1'b0;
        @(posedge CLK_50);
        #1;
        check("abort_gmem_valid_before", gmem_valid, 1);
        check("abort_busy_before", busy, 1);
        #2 RST_N = 1'b0;
        #1;
        check("abort_gmem_valid", gmem_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_led", led, 0);
        check("abort_err", err, 0);
        check("abort_run", run, 1);
        @(negedge CLK_50);
        RST_N = 1'b1;
        led_m = '0; err_m = 1'b0; gmem_delay = 0;

        issue(1, 32'h44, 32'h0BAD_F00D, 0, 8'h00);
        issue(9, $urandom, $urandom, 0, 8'h00);
        check("unknown_err", err, 1);

        // Randomized calls
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0:       issue(1, $urandom, $urandom, 0, 8'h00);
                1:       issue(2, $urandom, $urandom, int'($urandom_range(0, 4)), 8'h00);
                2, 3:    issue(int'($urandom_range(3, 5)), $urandom, $urandom_range(0, 7), 0, 8'h00);
                4:       issue(6, $urandom, $urandom, int'($urandom_range(0, 4)), 8'($urandom));
                default: issue(int'($urandom_range(7, 31)), $urandom, $urandom, 0, 8'h00);
            endcase
        end

`ifdef SYSCALL_TIMEOUT_EN
        issue(6, 32'h0, 32'h0, -1, 8'h00);
        check("timeout_result_hold", result, 32'hFFFF_FFFF);
`endif

        // Halt, then every further call must be ignored
        issue(0, 32'h0, 32'h0, 0, 8'h00);
        issue(1, 32'h80, 32'h1111_2222, 0, 8'h00);
        issue(2, 32'h84, 32'h3333_4444, 0, 8'h00);
        issue(3, $urandom, 32'd3, 0, 8'h00);
        issue(6, 32'h0, 32'h0, 0, 8'h00);
        repeat (3) @(negedge CLK_50);
        check("halt_run_stays_low", run, 0);
        check("halt_busy", busy, 0);

        check("smem_pending", smem_exp.size(), 0);
        check("gmem_pending", gmem_exp.size(), 0);
        check("result_pending", res_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
